// File: rtl/fifo_demo_top.sv
// Self-running FIFO demonstrator: an incrementing producer feeds a 64-entry FIFO that a periodic tick drains.
// Build option: define FIFO_FWFT_EN for a first-word-fall-through read port.
`timescale 1ns/1ps
module fifo_demo_top #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] fifo_din_test,
  output logic [7:0] fifo_dout_test,
  output logic [6:0] data_count_test,
  output logic       rd_en_test,
  output logic       wr_en_test,
  output logic       one_second_tick_test,
  output logic       one_second_pulse_test,
  output logic [7:0] count_test,
  output logic       fifo_empty_test
);
  localparam int unsigned DEPTH = 64;
  localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;
  logic [5:0]    wp;
  logic [5:0]    rp;
  logic [7:0]    mem [DEPTH];
  logic          full;
  logic [6:0]    count_next;

  assign fifo_din_test = count_test;

  // Full is judged on the pre-pop occupancy, so a tick on a full FIFO pops without a push.
  always_comb begin
    full                 = (data_count_test == 7'd64);
    wr_en_test           = !reset && !full;
    one_second_tick_test = !reset && (tick_cnt == TICK_LAST);
    rd_en_test           = one_second_tick_test && !fifo_empty_test;
    count_next           = data_count_test;
    case ({wr_en_test, rd_en_test})
      2'b10:   count_next = data_count_test + 7'd1;
      2'b01:   count_next = data_count_test - 7'd1;
      default: count_next = data_count_test;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt              <= '0;
      one_second_pulse_test <= 1'b0;
    end else if (one_second_tick_test) begin
      tick_cnt              <= '0;
      one_second_pulse_test <= ~one_second_pulse_test;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp              <= '0;
      rp              <= '0;
      count_test      <= '0;
      data_count_test <= '0;
      fifo_empty_test <= 1'b1;
    end else begin
      if (wr_en_test) begin
        wp         <= wp + 6'd1;
        count_test <= count_test + 8'd1;
      end
      if (rd_en_test) begin
        rp <= rp + 6'd1;
      end
      data_count_test <= count_next;
      fifo_empty_test <= (count_next == 7'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_test) begin
      mem[wp] <= count_test;
    end
  end

`ifdef FIFO_FWFT_EN
  assign fifo_dout_test = fifo_empty_test ? '0 : mem[rp];
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_dout_test <= '0;
    end else if (rd_en_test) begin
      fifo_dout_test <= mem[rp];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_demo_top.sv
// Directed bench for fifo_demo_top: reset hold, fill, first tick, steady drain, count wrap, async reset.
`timescale 1ns/1ps
module tb_fifo_demo_top;
  logic       clk;
  logic       reset;
  logic [7:0] fifo_din_test;
  logic [7:0] fifo_dout_test;
  logic [6:0] data_count_test;
  logic       rd_en_test;
  logic       wr_en_test;
  logic       one_second_tick_test;
  logic       one_second_pulse_test;
  logic [7:0] count_test;
  logic       fifo_empty_test;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  fifo_demo_top #(.TICK_DIV(100)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .fifo_din_test         (fifo_din_test),
    .fifo_dout_test        (fifo_dout_test),
    .data_count_test       (data_count_test),
    .rd_en_test            (rd_en_test),
    .wr_en_test            (wr_en_test),
    .one_second_tick_test  (one_second_tick_test),
    .one_second_pulse_test (one_second_pulse_test),
    .count_test            (count_test),
    .fifo_empty_test       (fifo_empty_test)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  // Edge k after reset release is numbered k.
  always @(posedge clk) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic wait_edge(input int target);
    while (edge_n < target) @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_dout"},  fifo_dout_test, 0);
    check({tag, "_dcnt"},  data_count_test, 0);
    check({tag, "_empty"}, fifo_empty_test, 1);
    check({tag, "_count"}, count_test, 0);
    check({tag, "_din"},   fifo_din_test, 0);
    check({tag, "_pulse"}, one_second_pulse_test, 0);
    check({tag, "_tick"},  one_second_tick_test, 0);
    check({tag, "_wr"},    wr_en_test, 0);
    check({tag, "_rd"},    rd_en_test, 0);
  endtask

  initial begin
    reset = 1'b1;
    #50;
    check_cleared("rst_hold");
    #50;
    reset = 1'b0;

    wait_edge(1);
    check("edge1_count", count_test, 1);
    check("edge1_dcnt", data_count_test, 1);
    check("edge1_empty", fifo_empty_test, 0);

    wait_edge(64);
    check("fill_dcnt", data_count_test, 64);
    check("fill_count", count_test, 64);
    check("fill_wr", wr_en_test, 0);
    check("fill_empty", fifo_empty_test, 0);
    check("fill_rd", rd_en_test, 0);

    wait_edge(99);
    check("t1_tick", one_second_tick_test, 1);
    check("t1_rd", rd_en_test, 1);
    check("t1_wr_full", wr_en_test, 0);
    check("t1_pulse_pre", one_second_pulse_test, 0);

    wait_edge(100);
    check("t1_dout", fifo_dout_test, 0);
    check("t1_dcnt", data_count_test, 63);
    check("t1_pulse", one_second_pulse_test, 1);
    check("t1_tick_off", one_second_tick_test, 0);
    check("t1_wr_resume", wr_en_test, 1);

    wait_edge(101);
    check("t1_refill_dcnt", data_count_test, 64);
    check("t1_refill_count", count_test, 65);
    check("t1_dout_hold", fifo_dout_test, 0);

    for (int n = 2; n <= 199; n++) begin
      wait_edge(100 * n - 1);
      check("tick_hi", one_second_tick_test, 1);
      wait_edge(100 * n);
      check("pop_dout", fifo_dout_test, (n - 1) % 256);
      check("pop_pulse", one_second_pulse_test, n % 2);
      check("pop_count", count_test, (63 + n) % 256);
      check("pop_dcnt", data_count_test, 63);
    end

    // Between edges: reset must clear state without waiting for a clock.
    #0.3;
    reset = 1'b1;
    #0.2;
    check_cleared("async_rst");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    wait_edge(1);
    check("refill1_count", count_test, 1);
    check("refill1_dcnt", data_count_test, 1);
    check("refill1_dout", fifo_dout_test, 0);
    wait_edge(3);
    check("refill3_din", fifo_din_test, 3);
    check("refill3_dcnt", data_count_test, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
